mda_crtc: RTL
=============

# mda_crtc

Register and timing-control block for the MDA display path. It decodes CPU I/O cycles in 03B0h–03BFh and implements a subset of the MC6845 register file (index/data pair), the mode control register at 03B8h and the status register at 03BAh. It supplies the character fetch pipeline with a frame-latched display start address, cursor position and shape, cursor and attribute blink phases, and a video enable. Retrace inputs are synchronous to `iClk`; synchronisation from the 25 MHz domain is done upstream.

## Interface
- No parameters.

- `iClk` in 1: single clock for the whole block, CPU domain.
- `iRstN` in 1: asynchronous, active-low reset.
- `iIoAddr` in 16: I/O port address.
- `iIoData` in 8: I/O write data.
- `iIoWr` in 1: I/O write strobe, one cycle per access.
- `iIoRd` in 1: I/O read strobe, one cycle per access.
- `oIoSel` out 1: combinational; high when `iIoAddr[15:4]==12'h03B`.
- `oIoData` out 8: registered read data.
- `iHBlank` in 1: horizontal retrace, already in the `iClk` domain.
- `iVBlank` in 1: vertical retrace, already in the `iClk` domain.
- `oStartAddr` out 14: display start address, in character cells.
- `oCursorAddr` out 14: cursor cell address.
- `oCursorStart` out 5: first scanline of the cursor.
- `oCursorEnd` out 5: last scanline of the cursor.
- `oCursorOn` out 1: cursor visible this frame, after applying mode and blink.
- `oBlinkPhase` out 1: attribute blink phase. 0 when blink is disabled.
- `oVideoEn` out 1: mode bit 3. When 0, the pixel path outputs black.
- `oHiRes` out 1: mode bit 0.

## Operation
- **Port decode** (`oIoSel` high):
  - Even ports 3B0/2/4/6 access the index register.
  - Odd ports 3B1/3/5/7 access the data register.
  - 3B8 is the mode register.
  - 3BA is the status register.
  - All other ports: writes are ignored, reads return FFh.
- **Index register**: 5 bits. A write takes `iIoData[4:0]`. A read returns `{3'b000, index}`.
- **Data writes**, by index:
  - R0–R9: stored (R0 8b, R1 8b, R2 8b, R3 8b, R4 7b, R5 5b, R6 7b, R7 7b, R8 2b, R9 5b). They drive no output.
  - R10: cursor start, 7b. Bits 6:5 are the blink mode, bits 4:0 the start line.
  - R11: cursor end, 5b.
  - R12/R13: start address high (6b) / low (8b), written into a shadow register.
  - R14/R15: cursor address high (6b) / low (8b), applied immediately.
  - R16, R17, and indices 18–31: writes are ignored.
- **Data reads**, by index:
  - R14/R15: return the stored value, zero-extended.
  - R16/R17 (light pen): return 00h.
  - All other indices: return 00h.
- **Mode register (3B8)**:
  - Write stores bits 0, 3 and 5.
  - Read returns FFh (write-only).
  - `oHiRes` = bit 0, `oVideoEn` = bit 3, blink enable = bit 5.
- **Status register (3BA)**, read only:
  - Bits 7:4 = 1111, bits 2:1 = 00.
  - Bit 0 = `iHBlank | iVBlank`.
  - Bit 3 = `iVBlank`.
  - Values are sampled in the read cycle.
- **Frame edge**: `vb_d` is a register holding `iVBlank`. `vb_rise = iVBlank & ~vb_d`.
- **On each `vb_rise`**:
  - The 5-bit frame counter increments, wrapping 31→0.
  - `oStartAddr` is loaded from the shadow register.
- **Cursor visibility**, from R10[6:5]:
  - 00: `oCursorOn` = 1.
  - 01: `oCursorOn` = 0.
  - 10: `oCursorOn` = frame counter bit 3 (1/16 field rate).
  - 11: `oCursorOn` = frame counter bit 4 (1/32 field rate).
- **Attribute blink**: `oBlinkPhase` = frame counter bit 4 & mode bit 5.

## Timing
- **Reset**: all registers clear to 0, including the index, R0–R15, the shadow register, mode, the frame counter and `vb_d`.
- **Output values at reset**:
  - `oIoData`=00h, `oStartAddr`=0, `oCursorAddr`=0, `oCursorStart`=0, `oCursorEnd`=0.
  - `oCursorOn`=1 (mode 00), `oBlinkPhase`=0, `oVideoEn`=0, `oHiRes`=0.
- **Write latency**: a write is visible on the register outputs the cycle after the `iIoWr` cycle.
  - R12/R13 affect `oStartAddr` only at the next `vb_rise`.
- **Read latency**: `oIoData` is valid the cycle after `iIoRd` and holds until the next read. An unselected read leaves `oIoData` unchanged.
- **`iIoWr` and `iIoRd` in the same cycle**: the write takes effect; `oIoData` returns the pre-write value.
- **`vb_rise` in the same cycle as an R12/R13 write**: `oStartAddr` loads the old shadow value. The new value applies one frame later.
- **`iVBlank` held high**: exactly one increment and one load per rising edge.
- **Reset asserted mid-frame**: every output clears immediately (asynchronous). On release, the first `vb_rise` is detected normally.

## Test plan
- **Reset values**: assert `iRstN`=0, then release → all outputs hold their reset values; a read of port 3B4 returns 00h.
- **Start address latching**:
  - Stimulus: write 3B4←0Ch, 3B5←12h, 3B4←0Dh, 3B5←34h.
  - Required: `oStartAddr` stays 0 until the next `iVBlank` rise, then becomes 1234h.
  - A write coincident with the rise is deferred by one frame.
- **Cursor readback**: write R14←3Fh (stored as 6 bits), R15←ABh → `oCursorAddr`=3FABh; reading R15 returns ABh, reading R16 returns 00h, reading R0 returns 00h.
- **Cursor blink**: R10←40h → `oCursorOn` toggles every 8 `vb_rise`. R10←60h → toggles every 16. R10←20h → `oCursorOn` stays 0.
- **Mode and attribute blink**:
  - 3B8←29h → `oVideoEn`=1, `oHiRes`=1, and `oBlinkPhase` follows frame counter bit 4 (high for frames 16–31).
  - 3B8←09h → `oBlinkPhase`=0.
  - Reading 3B8 returns FFh.
- **Status register**:
  - `iHBlank`=1, `iVBlank`=0 → a 3BA read returns F1h.
  - `iVBlank`=1 → returns F9h.
  - Both inputs 0 → returns F0h.
  - A read of 3BF returns FFh.

Source files
------------

// File: rtl/mda_crtc.sv
`default_nettype none
// ============================================================================
//  Module   : mda_crtc
//  Purpose  : CPU-facing register block and frame timing control for the MDA
//             display path. Decodes I/O ports 03B0h-03BFh and provides an
//             MC6845-style index/data register pair, the mode control register
//             (03B8h) and the status register (03BAh). Supplies the character
//             fetch pipeline with a frame-latched start address, the cursor
//             address and shape, cursor/attribute blink phases and video enable.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    iClk          in   1   single clock, CPU domain
//    iRstN         in   1   asynchronous active-low reset
//    iIoAddr       in  16   I/O port address
//    iIoData       in   8   I/O write data
//    iIoWr         in   1   I/O write strobe (one cycle per access)
//    iIoRd         in   1   I/O read strobe (one cycle per access)
//    oIoSel        out  1   combinational block select (03B0h-03BFh)
//    oIoData       out  8   registered read data, held until the next read
//    iHBlank       in   1   horizontal retrace, iClk domain
//    iVBlank       in   1   vertical retrace, iClk domain
//    oStartAddr    out 14   display start address, latched at frame start
//    oCursorAddr   out 14   cursor cell address
//    oCursorStart  out  5   first cursor scanline
//    oCursorEnd    out  5   last cursor scanline
//    oCursorOn     out  1   cursor visible this frame
//    oBlinkPhase   out  1   attribute blink phase
//    oVideoEn      out  1   video enable (mode bit 3)
//    oHiRes        out  1   high-resolution mode (mode bit 0)
// ============================================================================
module mda_crtc (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic [15:0] iIoAddr,
    input  logic [7:0]  iIoData,
    input  logic        iIoWr,
    input  logic        iIoRd,
    output logic        oIoSel,
    output logic [7:0]  oIoData,
    input  logic        iHBlank,
    input  logic        iVBlank,
    output logic [13:0] oStartAddr,
    output logic [13:0] oCursorAddr,
    output logic [4:0]  oCursorStart,
    output logic [4:0]  oCursorEnd,
    output logic        oCursorOn,
    output logic        oBlinkPhase,
    output logic        oVideoEn,
    output logic        oHiRes
);

    // CRTC register indices that have behaviour beyond plain storage
    localparam logic [4:0] c_IDX_CUR_START = 5'd10;
    localparam logic [4:0] c_IDX_CUR_END   = 5'd11;
    localparam logic [4:0] c_IDX_START_HI  = 5'd12;
    localparam logic [4:0] c_IDX_START_LO  = 5'd13;
    localparam logic [4:0] c_IDX_CUR_HI    = 5'd14;
    localparam logic [4:0] c_IDX_CUR_LO    = 5'd15;

    localparam logic [3:0] c_PORT_MODE     = 4'h8;
    localparam logic [3:0] c_PORT_STATUS   = 4'hA;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [4:0]  r_index;
    // R0-R9: timing registers kept for software compatibility only
    logic [7:0]  r_r0, r_r1, r_r2, r_r3;
    logic [6:0]  r_r4;
    logic [4:0]  r_r5;
    logic [6:0]  r_r6, r_r7;
    logic [1:0]  r_r8;
    logic [4:0]  r_r9;
    logic [6:0]  r_cur_start;       // [6:5] blink mode, [4:0] start line
    logic [4:0]  r_cur_end;
    logic [13:0] r_start_shadow;    // CPU-visible start address, not yet displayed
    logic [13:0] r_start_addr;      // start address in use for the current frame
    logic [13:0] r_cur_addr;
    logic        r_mode_hires;
    logic        r_mode_video;
    logic        r_mode_blink;
    logic [4:0]  r_frame_cnt;
    logic        r_vb_d;
    logic [7:0]  r_io_data;

    // ------------------------------------------------------------------
    // Port decode
    // ------------------------------------------------------------------
    logic       w_sel;
    logic [3:0] w_port;
    logic       w_is_crtc;          // 3B0-3B7
    logic       w_is_index;
    logic       w_is_data;
    logic       w_wr;
    logic       w_rd;
    logic       w_vb_rise;

    assign w_sel      = (iIoAddr[15:4] == 12'h03B);
    assign w_port     = iIoAddr[3:0];
    assign w_is_crtc  = ~w_port[3];
    assign w_is_index = w_is_crtc & ~w_port[0];
    assign w_is_data  = w_is_crtc &  w_port[0];
    assign w_wr       = iIoWr & w_sel;
    assign w_rd       = iIoRd & w_sel;
    assign w_vb_rise  = iVBlank & ~r_vb_d;

    // ------------------------------------------------------------------
    // Read data mux. Everything is sampled from the current register
    // contents, so a simultaneous write is never visible in this read.
    // ------------------------------------------------------------------
    logic [7:0] w_rd_data;

    always_comb begin
        w_rd_data = 8'hFF;
        if (w_is_index) begin
            w_rd_data = {3'b000, r_index};
        end else if (w_is_data) begin
            case (r_index)
                c_IDX_CUR_HI: w_rd_data = {2'b00, r_cur_addr[13:8]};
                c_IDX_CUR_LO: w_rd_data = r_cur_addr[7:0];
                default:      w_rd_data = 8'h00;   // write-only or light pen
            endcase
        end else if (w_port == c_PORT_STATUS) begin
            w_rd_data = {4'hF, iVBlank, 2'b00, iHBlank | iVBlank};
        end
    end

    // ------------------------------------------------------------------
    // Register file writes
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_index        <= '0;
            r_r0           <= '0;
            r_r1           <= '0;
            r_r2           <= '0;
            r_r3           <= '0;
            r_r4           <= '0;
            r_r5           <= '0;
            r_r6           <= '0;
            r_r7           <= '0;
            r_r8           <= '0;
            r_r9           <= '0;
            r_cur_start    <= '0;
            r_cur_end      <= '0;
            r_start_shadow <= '0;
            r_cur_addr     <= '0;
            r_mode_hires   <= 1'b0;
            r_mode_video   <= 1'b0;
            r_mode_blink   <= 1'b0;
        end else if (w_wr) begin
            if (w_is_index) begin
                r_index <= iIoData[4:0];
            end else if (w_is_data) begin
                case (r_index)
                    5'd0:            r_r0 <= iIoData;
                    5'd1:            r_r1 <= iIoData;
                    5'd2:            r_r2 <= iIoData;
                    5'd3:            r_r3 <= iIoData;
                    5'd4:            r_r4 <= iIoData[6:0];
                    5'd5:            r_r5 <= iIoData[4:0];
                    5'd6:            r_r6 <= iIoData[6:0];
                    5'd7:            r_r7 <= iIoData[6:0];
                    5'd8:            r_r8 <= iIoData[1:0];
                    5'd9:            r_r9 <= iIoData[4:0];
                    c_IDX_CUR_START: r_cur_start <= iIoData[6:0];
                    c_IDX_CUR_END:   r_cur_end   <= iIoData[4:0];
                    c_IDX_START_HI:  r_start_shadow[13:8] <= iIoData[5:0];
                    c_IDX_START_LO:  r_start_shadow[7:0]  <= iIoData;
                    c_IDX_CUR_HI:    r_cur_addr[13:8]     <= iIoData[5:0];
                    c_IDX_CUR_LO:    r_cur_addr[7:0]      <= iIoData;
                    default: ;                            // R16 and above ignored
                endcase
            end else if (w_port == c_PORT_MODE) begin
                r_mode_hires <= iIoData[0];
                r_mode_video <= iIoData[3];
                r_mode_blink <= iIoData[5];
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame timing: one counter step and one start-address load per
    // rising edge of vertical retrace. The load takes the shadow value
    // from before any write in the same cycle, deferring it a frame.
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_vb_d       <= 1'b0;
            r_frame_cnt  <= '0;
            r_start_addr <= '0;
        end else begin
            r_vb_d <= iVBlank;
            if (w_vb_rise) begin
                r_frame_cnt  <= r_frame_cnt + 5'd1;
                r_start_addr <= r_start_shadow;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data register: unselected reads leave the last value in place
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_io_data <= '0;
        end else if (w_rd) begin
            r_io_data <= w_rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Cursor visibility from the blink mode field
    // ------------------------------------------------------------------
    logic w_cursor_on;

    always_comb begin
        w_cursor_on = 1'b1;
        case (r_cur_start[6:5])
            2'b00:   w_cursor_on = 1'b1;
            2'b01:   w_cursor_on = 1'b0;
            2'b10:   w_cursor_on = r_frame_cnt[3];
            default: w_cursor_on = r_frame_cnt[4];
        endcase
    end

    // Timing registers have no consumer inside this block
    logic w_unused_regs;
    assign w_unused_regs = ^{r_r0, r_r1, r_r2, r_r3, r_r4, r_r5,
                             r_r6, r_r7, r_r8, r_r9};

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign oIoSel       = w_sel;
    assign oIoData      = r_io_data;
    assign oStartAddr   = r_start_addr;
    assign oCursorAddr  = r_cur_addr;
    assign oCursorStart = r_cur_start[4:0];
    assign oCursorEnd   = r_cur_end;
    assign oCursorOn    = w_cursor_on;
    assign oBlinkPhase  = r_frame_cnt[4] & r_mode_blink;
    assign oVideoEn     = r_mode_video;
    assign oHiRes       = r_mode_hires;

endmodule
`default_nettype wire
